// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory bus port between instruction fetch and MEM-stage load/store
module mem_port_arbiter #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic [31:0] if_rdata,
    output logic        if_done,
    output logic        if_err,
    input  logic        mem_req,
    input  logic        mem_we,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic [3:0]  mem_sel,
    output logic [31:0] mem_rdata,
    output logic        mem_done,
    output logic        mem_err,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_sel,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata,
    output logic        stall_o
);
    typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_MEM} state_t;
    localparam logic [7:0] LAST_WAIT = 8'(TIMEOUT - 1);
    state_t      state_q, state_d;
    logic        last_mem_q, last_mem_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d, wdata_q, wdata_d;
    logic [3:0]  sel_q, sel_d;
    logic        if_done_q, if_done_d, if_err_q, if_err_d;
    logic        mem_done_q, mem_done_d, mem_err_q, mem_err_d;
    logic [31:0] if_rdata_q, if_rdata_d, mem_rdata_q, mem_rdata_d;
    logic        if_pend, mem_pend, gnt_mem, finish;
    // a request whose done is showing this cycle is already satisfied and must not be re-granted
    assign if_pend  = if_req & ~if_done_q;
    assign mem_pend = mem_req & ~mem_done_q;
    assign gnt_mem  = mem_pend & (~if_pend | ~last_mem_q);
    assign finish   = bus_ack | (cnt_q == LAST_WAIT);
    assign bus_req   = state_q != IDLE;
    assign bus_we    = we_q;
    assign bus_addr  = addr_q;
    assign bus_wdata = wdata_q;
    assign bus_sel   = sel_q;
    assign if_rdata  = if_rdata_q;
    assign if_done   = if_done_q;
    assign if_err    = if_err_q;
    assign mem_rdata = mem_rdata_q;
    assign mem_done  = mem_done_q;
    assign mem_err   = mem_err_q;
    assign stall_o   = (if_req & ~if_done_q) | (mem_req & ~mem_done_q);
    // next-state: grant and latch in IDLE, complete on ack or wait-limit in BUSY
    always_comb begin
        state_d     = state_q;
        last_mem_d  = last_mem_q;
        cnt_d       = cnt_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        sel_d       = sel_q;
        if_done_d   = 1'b0;
        if_err_d    = 1'b0;
        mem_done_d  = 1'b0;
        mem_err_d   = 1'b0;
        if_rdata_d  = if_rdata_q;
        mem_rdata_d = mem_rdata_q;
        if (state_q == IDLE) begin
            if (if_pend | mem_pend) begin
                state_d    = gnt_mem ? BUSY_MEM : BUSY_IF;
                last_mem_d = gnt_mem;
                cnt_d      = '0;
                we_d       = gnt_mem & mem_we;
                addr_d     = gnt_mem ? mem_addr : if_addr;
                wdata_d    = gnt_mem ? mem_wdata : '0;
                sel_d      = gnt_mem ? mem_sel : 4'hF;
            end
        end else if (finish) begin
            state_d    = IDLE;
            if_done_d  = state_q == BUSY_IF;
            mem_done_d = state_q != BUSY_IF;
            if_err_d   = if_done_d & ~bus_ack;
            mem_err_d  = mem_done_d & ~bus_ack;
            if (if_done_d) if_rdata_d = bus_ack ? bus_rdata : '0;
            else mem_rdata_d = (bus_ack & ~we_q) ? bus_rdata : '0;
        end else begin
            cnt_d = cnt_q + 8'd1;
        end
    end
    // state and result registers; reset abandons any bus cycle without a done pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            last_mem_q  <= 1'b0;
            cnt_q       <= '0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            sel_q       <= '0;
            if_done_q   <= 1'b0;
            if_err_q    <= 1'b0;
            mem_done_q  <= 1'b0;
            mem_err_q   <= 1'b0;
            if_rdata_q  <= '0;
            mem_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            last_mem_q  <= last_mem_d;
            cnt_q       <= cnt_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            sel_q       <= sel_d;
            if_done_q   <= if_done_d;
            if_err_q    <= if_err_d;
            mem_done_q  <= mem_done_d;
            mem_err_q   <= mem_err_d;
            if_rdata_q  <= if_rdata_d;
            mem_rdata_q <= mem_rdata_d;
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed scenarios plus randomized traffic against a transaction-level model
module tb_mem_port_arbiter;
    localparam int T = 4;
    logic        clk = 1'b0, rst;
    logic        if_req, if_done, if_err;
    logic [31:0] if_addr, if_rdata;
    logic        mem_req, mem_we, mem_done, mem_err;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_sel;
    logic        bus_req, bus_we, bus_ack;
    logic [31:0] bus_addr, bus_wdata, bus_rdata;
    logic [3:0]  bus_sel;
    logic        stall_o;
    int n_cmp = 0, n_bad = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.TIMEOUT(T)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_done(if_done), .if_err(if_err),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_sel(mem_sel),
        .mem_rdata(mem_rdata), .mem_done(mem_done), .mem_err(mem_err),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_sel(bus_sel),
        .bus_ack(bus_ack), .bus_rdata(bus_rdata), .stall_o(stall_o)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        if_req = 0; if_addr = 0;
        mem_req = 0; mem_we = 0; mem_addr = 0; mem_wdata = 0; mem_sel = 0;
        bus_ack = 0; bus_rdata = 0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1; if_req = 1; mem_req = 1;
        tick(); tick();
        n_cmp++;
        if ({bus_req, bus_we, bus_addr, bus_wdata, bus_sel} !== 70'd0) begin
            n_bad++; $display("FAIL reset_bus: got %h want 0", {bus_req, bus_we, bus_addr, bus_wdata, bus_sel});
        end
        n_cmp++;
        if ({if_done, if_err, mem_done, mem_err} !== 4'd0) begin
            n_bad++; $display("FAIL reset_flags: got %b want 0000", {if_done, if_err, mem_done, mem_err});
        end
        n_cmp++;
        if ({if_rdata, mem_rdata} !== 64'd0) begin
            n_bad++; $display("FAIL reset_rdata: got %h want 0", {if_rdata, mem_rdata});
        end
        n_cmp++;
        if (stall_o !== 1'b1) begin
            n_bad++; $display("FAIL reset_stall: got %b want 1", stall_o);
        end
        rst = 0; if_req = 0; mem_req = 0;
        tick();
        n_cmp++;
        if (bus_req !== 1'b0) begin
            n_bad++; $display("FAIL reset_idle: got %b want 0", bus_req);
        end
    endtask

    task automatic test_if_read();
        if_req = 1; if_addr = 32'h100;
        tick();
        n_cmp++;
        if ({bus_req, bus_we, bus_addr, bus_wdata, bus_sel} !== {1'b1, 1'b0, 32'h100, 32'h0, 4'hF}) begin
            n_bad++; $display("FAIL if_read_bus: got %h want %h", {bus_req, bus_we, bus_addr, bus_wdata, bus_sel},
                              {1'b1, 1'b0, 32'h100, 32'h0, 4'hF});
        end
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (bus_req !== 1'b1 || if_done !== 1'b0) begin
                n_bad++; $display("FAIL if_read_wait[%0d]: got req=%b done=%b want req=1 done=0", i, bus_req, if_done);
            end
            if (i == 3) begin bus_ack = 1; bus_rdata = 32'hDEADBEEF; end
            tick();
        end
        bus_ack = 0; bus_rdata = 0;
        n_cmp++;
        if ({if_done, if_err, bus_req, mem_done} !== 4'b1000) begin
            n_bad++; $display("FAIL if_read_done: got %b want 1000", {if_done, if_err, bus_req, mem_done});
        end
        n_cmp++;
        if (if_rdata !== 32'hDEADBEEF) begin
            n_bad++; $display("FAIL if_read_rdata: got %h want deadbeef", if_rdata);
        end
        n_cmp++;
        if (stall_o !== 1'b0) begin
            n_bad++; $display("FAIL if_read_stall: got %b want 0", stall_o);
        end
        if_req = 0;
        tick();
        n_cmp++;
        if ({if_done, bus_req} !== 2'b00 || if_rdata !== 32'hDEADBEEF) begin
            n_bad++; $display("FAIL if_read_hold: got done=%b req=%b rdata=%h want 0 0 deadbeef", if_done, bus_req, if_rdata);
        end
    endtask

    task automatic test_mem_store();
        mem_req = 1; mem_we = 1; mem_addr = 32'h2000; mem_wdata = 32'h12345678; mem_sel = 4'b0011;
        tick();
        n_cmp++;
        if ({bus_req, bus_we, bus_addr, bus_wdata, bus_sel} !== {1'b1, 1'b1, 32'h2000, 32'h12345678, 4'b0011}) begin
            n_bad++; $display("FAIL store_bus: got %h want %h", {bus_req, bus_we, bus_addr, bus_wdata, bus_sel},
                              {1'b1, 1'b1, 32'h2000, 32'h12345678, 4'b0011});
        end
        bus_ack = 1; bus_rdata = 32'hCAFEF00D;
        tick();
        bus_ack = 0; bus_rdata = 0;
        n_cmp++;
        if ({mem_done, mem_err, if_done, bus_req} !== 4'b1000 || mem_rdata !== 32'h0) begin
            n_bad++; $display("FAIL store_done: got %b rdata=%h want 1000 rdata=0", {mem_done, mem_err, if_done, bus_req}, mem_rdata);
        end
        mem_req = 0; mem_we = 0;
        tick();
        n_cmp++;
        if (mem_done !== 1'b0 || if_rdata !== 32'hDEADBEEF) begin
            n_bad++; $display("FAIL store_pulse: got done=%b if_rdata=%h want 0 deadbeef", mem_done, if_rdata);
        end
    endtask

    task automatic test_spurious_ack();
        bus_ack = 1; bus_rdata = 32'h55AA55AA;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_cmp++;
            if ({bus_req, if_done, mem_done} !== 3'b000 || if_rdata !== 32'hDEADBEEF) begin
                n_bad++; $display("FAIL spurious_ack[%0d]: got %b if_rdata=%h want 000 deadbeef", i, {bus_req, if_done, mem_done}, if_rdata);
            end
        end
        bus_ack = 0; bus_rdata = 0;
    endtask

    task automatic test_reset_mid();
        mem_req = 1; mem_we = 0; mem_addr = 32'h44; mem_sel = 4'hF;
        tick();
        n_cmp++;
        if (bus_req !== 1'b1) begin
            n_bad++; $display("FAIL rstmid_busy: got %b want 1", bus_req);
        end
        tick();
        rst = 1;
        tick();
        n_cmp++;
        if ({bus_req, mem_done, mem_err} !== 3'b000 || if_rdata !== 32'h0) begin
            n_bad++; $display("FAIL rstmid_abort: got %b if_rdata=%h want 000 0", {bus_req, mem_done, mem_err}, if_rdata);
        end
        rst = 0; mem_req = 0;
        tick();
        n_cmp++;
        if ({bus_req, mem_done} !== 2'b00) begin
            n_bad++; $display("FAIL rstmid_nodone: got %b want 00", {bus_req, mem_done});
        end
        if_req = 1; if_addr = 32'h300;
        tick();
        n_cmp++;
        if ({bus_req, bus_addr, bus_sel} !== {1'b1, 32'h300, 4'hF}) begin
            n_bad++; $display("FAIL rstmid_regrant: got %h want %h", {bus_req, bus_addr, bus_sel}, {1'b1, 32'h300, 4'hF});
        end
        bus_ack = 1; bus_rdata = 32'h0BADF00D;
        tick();
        bus_ack = 0; bus_rdata = 0;
        n_cmp++;
        if ({if_done, mem_done} !== 2'b10 || if_rdata !== 32'h0BADF00D) begin
            n_bad++; $display("FAIL rstmid_done: got %b rdata=%h want 10 0badf00d", {if_done, mem_done}, if_rdata);
        end
        if_req = 0;
        tick();
    endtask

    task automatic test_contention();
        int done_n = 0;
        logic exp_mem = 1'b1;
        if_req = 1; if_addr = 32'h40;
        mem_req = 1; mem_we = 0; mem_addr = 32'h80; mem_wdata = 0; mem_sel = 4'hF;
        for (int c = 0; c < 40 && done_n < 4; c++) begin
            tick();
            bus_ack = 0;
            if (if_done === 1'b1 || mem_done === 1'b1) begin
                n_cmp++;
                if (mem_done !== exp_mem || if_done === mem_done) begin
                    n_bad++; $display("FAIL contention_order[%0d]: got if=%b mem=%b want mem=%b", done_n, if_done, mem_done, exp_mem);
                end
                n_cmp++;
                if ((exp_mem ? mem_rdata : if_rdata) !== 32'hA0 + 32'(done_n)) begin
                    n_bad++; $display("FAIL contention_rdata[%0d]: got %h want %h", done_n, exp_mem ? mem_rdata : if_rdata, 32'hA0 + done_n);
                end
                done_n++;
                n_cmp++;
                if (stall_o !== (done_n < 4)) begin
                    n_bad++; $display("FAIL contention_stall_done[%0d]: got %b want %b", done_n, stall_o, done_n < 4);
                end
                if (done_n == 3) mem_req = 0;
                if (done_n == 4) if_req = 0;
                exp_mem = ~exp_mem;
            end else begin
                n_cmp++;
                if (stall_o !== 1'b1) begin
                    n_bad++; $display("FAIL contention_stall[%0d]: got %b want 1", c, stall_o);
                end
            end
            if (bus_req === 1'b1) begin
                n_cmp++;
                if (bus_addr !== (exp_mem ? 32'h80 : 32'h40)) begin
                    n_bad++; $display("FAIL contention_grant[%0d]: got addr %h want %h", done_n, bus_addr, exp_mem ? 32'h80 : 32'h40);
                end
                bus_ack = 1; bus_rdata = 32'hA0 + 32'(done_n);
            end
        end
        n_cmp++;
        if (done_n != 4) begin
            n_bad++; $display("FAIL contention_budget: got %0d dones want 4", done_n);
        end
        if_req = 0; mem_req = 0; bus_ack = 0; bus_rdata = 0;
        tick();
    endtask

    task automatic test_timeout();
        int hi = 0;
        mem_req = 1; mem_we = 0; mem_addr = 32'h500; mem_sel = 4'hF;
        tick();
        for (int c = 0; c < 20 && bus_req === 1'b1; c++) begin
            hi++;
            bus_rdata = $urandom;
            tick();
        end
        bus_rdata = 0;
        n_cmp++;
        if (hi != T) begin
            n_bad++; $display("FAIL timeout_len: got %0d req cycles want %0d", hi, T);
        end
        n_cmp++;
        if ({mem_done, mem_err, if_done} !== 3'b110 || mem_rdata !== 32'h0) begin
            n_bad++; $display("FAIL timeout_err: got %b rdata=%h want 110 0", {mem_done, mem_err, if_done}, mem_rdata);
        end
        mem_req = 0;
        tick();
        n_cmp++;
        if ({mem_done, mem_err, bus_req} !== 3'b000) begin
            n_bad++; $display("FAIL timeout_after: got %b want 000", {mem_done, mem_err, bus_req});
        end
    endtask

    task automatic test_random();
        bit if_act = 0, mem_act = 0, txn = 0, last_mem = 0, prev;
        bit busy, dn, err, e_ifd, e_memd, pend_if, pend_mem;
        int g = 0, n = 0, lat = 0, who = 0;
        logic        t_we = 0;
        logic [31:0] t_addr = 0, t_wdata = 0, ack_rd = 0, exp_if_rd = 0, exp_mem_rd = 0;
        logic [3:0]  t_sel = 0;
        idle_inputs();
        rst = 1;
        tick();
        rst = 0;
        for (int k = 0; k < 3000; k++) begin
            tick();
            bus_ack = 0;
            busy = txn && k >= g && k < g + n;
            dn = txn && k == g + n;
            err = lat >= T;
            e_ifd = dn && who == 0;
            e_memd = dn && who == 1;
            if (e_ifd) exp_if_rd = err ? 32'h0 : ack_rd;
            if (e_memd) exp_mem_rd = (err || t_we) ? 32'h0 : ack_rd;
            n_cmp++;
            if (bus_req !== busy) begin
                n_bad++; $display("FAIL rnd_bus_req[%0d]: got %b want %b", k, bus_req, busy);
            end
            if (busy) begin
                n_cmp++;
                if ({bus_we, bus_addr, bus_wdata, bus_sel} !== {t_we, t_addr, t_wdata, t_sel}) begin
                    n_bad++; $display("FAIL rnd_bus_fields[%0d]: got %h want %h", k, {bus_we, bus_addr, bus_wdata, bus_sel}, {t_we, t_addr, t_wdata, t_sel});
                end
            end
            n_cmp++;
            if ({if_done, if_err, mem_done, mem_err} !== {e_ifd, e_ifd && err, e_memd, e_memd && err}) begin
                n_bad++; $display("FAIL rnd_flags[%0d]: got %b want %b", k, {if_done, if_err, mem_done, mem_err}, {e_ifd, e_ifd && err, e_memd, e_memd && err});
            end
            n_cmp++;
            if ({if_rdata, mem_rdata} !== {exp_if_rd, exp_mem_rd}) begin
                n_bad++; $display("FAIL rnd_rdata[%0d]: got %h %h want %h %h", k, if_rdata, mem_rdata, exp_if_rd, exp_mem_rd);
            end
            prev = if_act;
            if (e_ifd) if_act = $urandom_range(0, 1) == 1;
            else if (!if_act && !(busy && who == 0)) if_act = $urandom_range(0, 2) == 0;
            else if (if_act && busy && who == 0 && $urandom_range(0, 9) == 0) if_act = 0;
            if (!if_act || e_ifd || !prev) if_addr = $urandom;
            prev = mem_act;
            if (e_memd) mem_act = $urandom_range(0, 1) == 1;
            else if (!mem_act && !(busy && who == 1)) mem_act = $urandom_range(0, 2) == 0;
            else if (mem_act && busy && who == 1 && $urandom_range(0, 9) == 0) mem_act = 0;
            if (!mem_act || e_memd || !prev) begin
                mem_we = $urandom_range(0, 1) == 1; mem_addr = $urandom; mem_wdata = $urandom; mem_sel = 4'($urandom);
            end
            if_req = if_act;
            mem_req = mem_act;
            pend_if = if_act && !e_ifd;
            pend_mem = mem_act && !e_memd;
            if (!busy && (pend_if || pend_mem)) begin
                who = (pend_mem && (!pend_if || !last_mem)) ? 1 : 0;
                last_mem = who == 1;
                txn = 1; g = k + 1;
                lat = $urandom_range(0, T + 1);
                n = (lat < T ? lat : T - 1) + 1;
                t_we = (who == 1) && mem_we;
                t_addr = who == 1 ? mem_addr : if_addr;
                t_wdata = who == 1 ? mem_wdata : 32'h0;
                t_sel = who == 1 ? mem_sel : 4'hF;
            end
            bus_rdata = $urandom;
            if (busy && k == g + lat) begin
                bus_ack = 1; ack_rd = bus_rdata;
            end else if (!busy && $urandom_range(0, 3) == 0) begin
                bus_ack = 1;
            end
            #1;
            n_cmp++;
            if (stall_o !== ((if_act && !e_ifd) || (mem_act && !e_memd))) begin
                n_bad++; $display("FAIL rnd_stall[%0d]: got %b want %b", k, stall_o, (if_act && !e_ifd) || (mem_act && !e_memd));
            end
        end
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        rst = 1;
        test_reset();
        test_if_read();
        test_mem_store();
        test_spurious_ack();
        test_reset_mid();
        test_contention();
        test_timeout();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
